// File: rtl/cache_ctrl_assoc_pkg.sv
// Shared FSM state encodings and width helpers for the cache_ctrl_assoc controller.
package cache_ctrl_assoc_pkg;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_COMPARE    = 2'd1;
   localparam logic [1:0] ST_WRITE_BACK = 2'd2;
   localparam logic [1:0] ST_ALLOCATE   = 2'd3;

   // A direct-mapped cache still needs one bit to drive way_sel.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/cache_ctrl_assoc_victim_sel.sv
// Combinational tag compare and victim pick for one set: lowest matching way hits,
// lowest invalid way is preferred as victim, otherwise the round-robin pointer decides.
module cache_ctrl_assoc_victim_sel
   import cache_ctrl_assoc_pkg::*;
#(
   parameter  int WAYS  = 2,
   parameter  int TAG_W = 21,
   localparam int WAY_W = way_bits(WAYS)
) (
   input  logic [WAYS-1:0]       i_valid,
   input  logic [WAYS-1:0]       i_dirty,
   input  logic [WAYS*TAG_W-1:0] i_tags,
   input  logic [TAG_W-1:0]      i_tag,
   input  logic [WAY_W-1:0]      i_rr_ptr,
   output logic                  o_hit,
   output logic [WAY_W-1:0]      o_hit_way,
   output logic [WAY_W-1:0]      o_victim_way,
   output logic                  o_victim_dirty,
   output logic                  o_victim_rr
);

   logic             w_any_inv;
   logic [WAY_W-1:0] w_inv_way;

   always_comb begin
      o_hit          = 1'b0;
      o_hit_way      = '0;
      w_any_inv      = 1'b0;
      w_inv_way      = '0;
      o_victim_dirty = 1'b0;
      // Scan downwards so the lowest qualifying way is the last one assigned.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (i_valid[w] && (i_tags[w*TAG_W +: TAG_W] == i_tag)) begin
            o_hit     = 1'b1;
            o_hit_way = WAY_W'(w);
         end
         if (!i_valid[w]) begin
            w_any_inv = 1'b1;
            w_inv_way = WAY_W'(w);
         end
      end
      o_victim_rr  = ~w_any_inv;
      o_victim_way = w_any_inv ? w_inv_way : i_rr_ptr;
      for (int w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == o_victim_way)
            o_victim_dirty = i_valid[w] & i_dirty[w];
      end
   end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative write-back/write-allocate L1 controller FSM with per-set RR replacement.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_assoc
   import cache_ctrl_assoc_pkg::*;
#(
   parameter  int ADDR_W   = 32,
   parameter  int INDEX_W  = 7,
   parameter  int OFFSET_W = 4,
   parameter  int WAYS     = 2,
   parameter  int CNT_W    = 16,
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
   localparam int WAY_W    = way_bits(WAYS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld,
   input  logic                  st,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [WAYS-1:0]       way_valid,
   input  logic [WAYS-1:0]       way_dirty,
   input  logic [WAYS*TAG_W-1:0] way_tag,
   input  logic                  l2_ack,
   input  logic                  write_done,
   output logic                  hit,
   output logic                  miss,
   output logic                  load_ready,
   output logic                  write_l1,
   output logic                  write_l2,
   output logic                  read_l2,
   output logic [WAY_W-1:0]      way_sel,
   output logic [INDEX_W-1:0]    index,
   output logic                  busy,
   output logic [1:0]            state
`ifdef CACHE_STATS_EN
   ,
   output logic [CNT_W-1:0]      hit_cnt,
   output logic [CNT_W-1:0]      miss_cnt
`endif
);

   localparam int SETS = 2 ** INDEX_W;

   logic [1:0]         r_state;
   logic [TAG_W-1:0]   r_tag;
   logic [INDEX_W-1:0] r_index;
   logic               r_op_ld;
   logic [WAY_W-1:0]   r_victim;
   logic               r_victim_rr;

   logic               w_hit;
   logic [WAY_W-1:0]   w_hit_way;
   logic [WAY_W-1:0]   w_victim_way;
   logic               w_victim_dirty;
   logic               w_victim_rr;
   logic [WAY_W-1:0]   w_rr_ptr;
   logic               w_cmp;
   logic               w_wb;
   logic               w_alloc;
   logic               w_fill;
   logic               w_unused_offset;

   assign w_unused_offset = ^addr[OFFSET_W-1:0];

   cache_ctrl_assoc_victim_sel #(
      .WAYS  (WAYS),
      .TAG_W (TAG_W)
   ) u_victim_sel (
      .i_valid        (way_valid),
      .i_dirty        (way_dirty),
      .i_tags         (way_tag),
      .i_tag          (r_tag),
      .i_rr_ptr       (w_rr_ptr),
      .o_hit          (w_hit),
      .o_hit_way      (w_hit_way),
      .o_victim_way   (w_victim_way),
      .o_victim_dirty (w_victim_dirty),
      .o_victim_rr    (w_victim_rr)
   );

   assign w_cmp   = (r_state == ST_COMPARE);
   assign w_wb    = (r_state == ST_WRITE_BACK);
   assign w_alloc = (r_state == ST_ALLOCATE);
   assign w_fill  = w_alloc & l2_ack;

   generate
      if (WAYS > 1) begin : g_rr
         logic [WAY_W-1:0] r_rr [SETS];

         // The pointer only moves when it actually chose the victim; invalid-way fills leave it.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
            end else if (w_fill && r_victim_rr) begin
               r_rr[r_index] <= (r_rr[r_index] == WAY_W'(WAYS - 1)) ? '0
                                                                  : r_rr[r_index] + WAY_W'(1);
            end
         end

         assign w_rr_ptr = r_rr[r_index];
      end else begin : g_no_rr
         assign w_rr_ptr = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_tag       <= '0;
         r_index     <= '0;
         r_op_ld     <= 1'b0;
         r_victim    <= '0;
         r_victim_rr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ld || st) begin
                  r_tag   <= addr[ADDR_W-1 -: TAG_W];
                  r_index <= addr[OFFSET_W +: INDEX_W];
                  r_op_ld <= ~st;
                  r_state <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               if (w_hit) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_victim    <= w_victim_way;
                  r_victim_rr <= w_victim_rr;
                  r_state     <= w_victim_dirty ? ST_WRITE_BACK : ST_ALLOCATE;
               end
            end
            ST_WRITE_BACK: if (write_done) r_state <= ST_ALLOCATE;
            ST_ALLOCATE:   if (l2_ack)     r_state <= ST_COMPARE;
            default:       r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode straight from the state register so an async reset clears them at once.
   assign hit        = w_cmp & w_hit;
   assign miss       = w_cmp & ~w_hit;
   assign load_ready = hit & r_op_ld;
   assign write_l1   = (hit & ~r_op_ld) | w_fill;
   assign write_l2   = w_wb;
   assign read_l2    = w_alloc;
   assign way_sel    = w_cmp ? (w_hit ? w_hit_way : w_victim_way)
                             : ((w_wb | w_alloc) ? r_victim : '0);
   assign index      = r_index;
   assign busy       = (r_state != ST_IDLE);
   assign state      = r_state;

`ifdef CACHE_STATS_EN
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (hit)  r_hit_cnt  <= sat_inc(r_hit_cnt);
         if (miss) r_miss_cnt <= sat_inc(r_miss_cnt);
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule
